// File: rtl/pwm_carrier_if.sv
// Bundle of control inputs and carrier outputs for pwm_carrier_gen.
// Optional macro CARRIER_PHASE_SYNC_EN adds the phase sync line.
interface pwm_carrier_if #(
    parameter int CNT_W = 16,
    parameter int DIV_W = 8
);
    logic             en;
    logic             mode;
    logic [DIV_W-1:0] divider;
    logic [CNT_W-1:0] max_val;
    logic [CNT_W-1:0] carrier;
    logic             dir_up;
    logic             evt_peak;
    logic             evt_valley;

`ifdef CARRIER_PHASE_SYNC_EN
    logic             sync;

    modport master (
        output en, mode, divider, max_val, sync,
        input  carrier, dir_up, evt_peak, evt_valley
    );
    modport slave (
        input  en, mode, divider, max_val, sync,
        output carrier, dir_up, evt_peak, evt_valley
    );
`else
    modport master (
        output en, mode, divider, max_val,
        input  carrier, dir_up, evt_peak, evt_valley
    );
    modport slave (
        input  en, mode, divider, max_val,
        output carrier, dir_up, evt_peak, evt_valley
    );
`endif
endinterface

// File: rtl/pwm_carrier_gen.sv
// Triangle/sawtooth PWM carrier with prescaler and valley-synchronous reload.
// Optional macro CARRIER_PHASE_SYNC_EN enables the external phase sync input.
module pwm_carrier_gen #(
    parameter int CNT_W = 16,
    parameter int DIV_W = 8
) (
    input  logic          clk,
    input  logic          rst,
    pwm_carrier_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};
    localparam logic [DIV_W-1:0] DIV_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};

    logic [DIV_W-1:0] div_count_r;
    logic [DIV_W-1:0] div_act_r;
    logic [CNT_W-1:0] max_act_r;
    logic             mode_act_r;
    logic [CNT_W-1:0] count_r;
    logic             dir_up_r;
    logic             evt_peak_r;
    logic             evt_valley_r;

    logic             tick_s;
    logic             sync_s;
    logic             load_s;
    logic [CNT_W-1:0] max_s;
    logic             mode_s;
    logic             rising_s;
    logic [CNT_W-1:0] count_nxt_s;
    logic             dir_nxt_s;
    logic [DIV_W-1:0] div_count_nxt_s;
    logic             peak_nxt_s;
    logic             valley_nxt_s;

`ifdef CARRIER_PHASE_SYNC_EN
    assign sync_s = bus.sync;
`else
    assign sync_s = 1'b0;
`endif

    // Next-state of prescaler, carrier and direction for one enabled clock
    always_comb begin
        tick_s          = (div_count_r == div_act_r);
        load_s          = sync_s || (tick_s && (count_r == CNT_ZERO));
        max_s           = load_s ? bus.max_val : max_act_r;
        mode_s          = load_s ? bus.mode    : mode_act_r;
        rising_s        = load_s ? 1'b1        : dir_up_r;
        count_nxt_s     = count_r;
        dir_nxt_s       = dir_up_r;
        div_count_nxt_s = div_count_r + DIV_ONE;

        if (sync_s || tick_s) begin
            div_count_nxt_s = DIV_ZERO;
        end else begin
            div_count_nxt_s = div_count_r + DIV_ONE;
        end

        if (sync_s) begin
            count_nxt_s = CNT_ZERO;
            dir_nxt_s   = 1'b1;
        end else if (!tick_s) begin
            count_nxt_s = count_r;
            dir_nxt_s   = dir_up_r;
        end else if (max_s == CNT_ZERO) begin
            count_nxt_s = CNT_ZERO;
            dir_nxt_s   = 1'b1;
        end else if (mode_s) begin
            // Sawtooth: wrap straight back to zero after the peak
            count_nxt_s = (count_r >= max_s) ? CNT_ZERO : (count_r + CNT_ONE);
            dir_nxt_s   = 1'b1;
        end else if (rising_s) begin
            if (count_r >= (max_s - CNT_ONE)) begin
                count_nxt_s = max_s;
                dir_nxt_s   = 1'b0;
            end else begin
                count_nxt_s = count_r + CNT_ONE;
                dir_nxt_s   = 1'b1;
            end
        end else begin
            if (count_r <= CNT_ONE) begin
                count_nxt_s = CNT_ZERO;
                dir_nxt_s   = 1'b1;
            end else begin
                count_nxt_s = count_r - CNT_ONE;
                dir_nxt_s   = 1'b0;
            end
        end

        // Events fire only on the clock the carrier actually moves onto the extreme
        peak_nxt_s   = (count_nxt_s != count_r) && (count_nxt_s == max_s) && (max_s != CNT_ZERO);
        valley_nxt_s = (count_nxt_s != count_r) && (count_nxt_s == CNT_ZERO);
    end

    // State registers; en low freezes everything and silences events
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_count_r  <= DIV_ZERO;
            div_act_r    <= DIV_ZERO;
            max_act_r    <= CNT_ZERO;
            mode_act_r   <= 1'b0;
            count_r      <= CNT_ZERO;
            dir_up_r     <= 1'b1;
            evt_peak_r   <= 1'b0;
            evt_valley_r <= 1'b0;
        end else if (bus.en) begin
            div_count_r  <= div_count_nxt_s;
            count_r      <= count_nxt_s;
            dir_up_r     <= dir_nxt_s;
            evt_peak_r   <= peak_nxt_s;
            evt_valley_r <= valley_nxt_s;
            if (load_s) begin
                div_act_r  <= bus.divider;
                max_act_r  <= bus.max_val;
                mode_act_r <= bus.mode;
            end else begin
                div_act_r  <= div_act_r;
                max_act_r  <= max_act_r;
                mode_act_r <= mode_act_r;
            end
        end else begin
            evt_peak_r   <= 1'b0;
            evt_valley_r <= 1'b0;
        end
    end

    assign bus.carrier    = count_r;
    assign bus.dir_up     = dir_up_r;
    assign bus.evt_peak   = evt_peak_r;
    assign bus.evt_valley = evt_valley_r;
endmodule

// File: tb/tb_pwm_carrier_gen.sv
// Scoreboard bench for pwm_carrier_gen (CNT_W=8): expected carrier/dir/event tuples
// are queued per scenario and popped against the DUT after each clock edge.
module tb_pwm_carrier_gen;
    typedef struct packed {
        logic [7:0] c;
        logic       d;
        logic       p;
        logic       v;
    } exp_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    exp_t exp_q[$];
    exp_t e;
    exp_t obs;

    pwm_carrier_if #(.CNT_W(8), .DIV_W(8)) bus ();

    pwm_carrier_gen #(.CNT_W(8), .DIV_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void push(input int c, input bit d, input bit p, input bit v);
        exp_t t;
        t.c = 8'(c);
        t.d = d;
        t.p = p;
        t.v = v;
        exp_q.push_back(t);
    endfunction

    task automatic do_reset(input int dv, input int mx, input bit md);
        rst = 1'b1;
        bus.en = 1'b0;
        bus.divider = 8'(dv);
        bus.max_val = 8'(mx);
        bus.mode = md;
`ifdef CARRIER_PHASE_SYNC_EN
        bus.sync = 1'b0;
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.en = 1'b1;
    endtask

    task automatic test_reset();
        do_reset(0, 3, 1'b0);
        bus.en = 1'b0;
        push(0, 1'b1, 1'b0, 1'b0);
        push(0, 1'b1, 1'b0, 1'b0);
        obs = {bus.carrier, bus.dir_up, bus.evt_peak, bus.evt_valley};
        e = exp_q.pop_front();
        total++;
        if (obs !== e) begin
            bad++;
            $display("FAIL reset_state: got %h expected %h", obs, e);
        end
        bus.en = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        obs = {bus.carrier, bus.dir_up, bus.evt_peak, bus.evt_valley};
        e = exp_q.pop_front();
        total++;
        if (obs !== e) begin
            bad++;
            $display("FAIL async_reset: got %h expected %h", obs, e);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_triangle();
        do_reset(0, 3, 1'b0);
        push(1,1,0,0); push(2,1,0,0); push(3,0,1,0); push(2,0,0,0); push(1,0,0,0);
        push(0,1,0,1); push(1,1,0,0); push(2,1,0,0); push(3,0,1,0);
        for (int i = 0; i < 9; i++) begin
            @(posedge clk);
            #1;
            obs = {bus.carrier, bus.dir_up, bus.evt_peak, bus.evt_valley};
            e = exp_q.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL triangle step %0d: got %h expected %h", i, obs, e);
            end
        end
    endtask

    task automatic test_divider();
        do_reset(1, 2, 1'b0);
        push(1,1,0,0); push(1,1,0,0); push(2,0,1,0); push(2,0,0,0); push(1,0,0,0); push(1,0,0,0);
        push(0,1,0,1); push(0,1,0,0); push(1,1,0,0); push(1,1,0,0); push(2,0,1,0);
        for (int i = 0; i < 11; i++) begin
            @(posedge clk);
            #1;
            obs = {bus.carrier, bus.dir_up, bus.evt_peak, bus.evt_valley};
            e = exp_q.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL divider step %0d: got %h expected %h", i, obs, e);
            end
        end
    endtask

    task automatic test_sawtooth_mode_change();
        do_reset(0, 4, 1'b1);
        push(1,1,0,0); push(2,1,0,0); push(3,1,0,0); push(4,1,1,0); push(0,1,0,1); push(1,1,0,0);
        push(2,1,0,0); push(3,1,0,0); push(4,1,1,0); push(0,1,0,1);
        push(1,1,0,0); push(2,0,1,0); push(1,0,0,0); push(0,1,0,1);
        for (int i = 0; i < 14; i++) begin
            if (i == 6) begin
                bus.mode = 1'b0;
                bus.max_val = 8'd2;
            end
            @(posedge clk);
            #1;
            obs = {bus.carrier, bus.dir_up, bus.evt_peak, bus.evt_valley};
            e = exp_q.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL sawtooth step %0d: got %h expected %h", i, obs, e);
            end
        end
    endtask

    task automatic test_max_change();
        do_reset(0, 3, 1'b0);
        push(1,1,0,0); push(2,1,0,0); push(3,0,1,0); push(2,0,0,0); push(1,0,0,0); push(0,1,0,1);
        push(1,1,0,0); push(2,1,0,0); push(3,1,0,0); push(4,1,0,0); push(5,0,1,0); push(4,0,0,0);
        for (int i = 0; i < 12; i++) begin
            if (i == 2) bus.max_val = 8'd5;
            @(posedge clk);
            #1;
            obs = {bus.carrier, bus.dir_up, bus.evt_peak, bus.evt_valley};
            e = exp_q.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL max_change step %0d: got %h expected %h", i, obs, e);
            end
        end
    endtask

    task automatic test_en_hold();
        do_reset(0, 5, 1'b0);
        push(1,1,0,0); push(2,1,0,0);
        for (int k = 0; k < 10; k++) push(2,1,0,0);
        push(3,1,0,0); push(4,1,0,0); push(5,0,1,0);
        for (int i = 0; i < 15; i++) begin
            if (i == 2) bus.en = 1'b0;
            if (i == 12) bus.en = 1'b1;
            @(posedge clk);
            #1;
            obs = {bus.carrier, bus.dir_up, bus.evt_peak, bus.evt_valley};
            e = exp_q.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL en_hold step %0d: got %h expected %h", i, obs, e);
            end
        end
    endtask

    task automatic test_zero_and_one_max();
        do_reset(0, 0, 1'b0);
        for (int k = 0; k < 4; k++) push(0,1,0,0);
        push(1,0,1,0); push(0,1,0,1); push(1,0,1,0); push(0,1,0,1);
        for (int i = 0; i < 8; i++) begin
            if (i == 4) bus.max_val = 8'd1;
            @(posedge clk);
            #1;
            obs = {bus.carrier, bus.dir_up, bus.evt_peak, bus.evt_valley};
            e = exp_q.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL zero_one_max step %0d: got %h expected %h", i, obs, e);
            end
        end
    endtask

`ifdef CARRIER_PHASE_SYNC_EN
    task automatic test_sync();
        do_reset(0, 5, 1'b0);
        push(1,1,0,0); push(2,1,0,0); push(3,1,0,0); push(4,1,0,0); push(5,0,1,0);
        push(4,0,0,0); push(3,0,0,0); push(0,1,0,1); push(1,1,0,0); push(2,1,0,0);
        for (int i = 0; i < 10; i++) begin
            bus.sync = (i == 7);
            @(posedge clk);
            #1;
            obs = {bus.carrier, bus.dir_up, bus.evt_peak, bus.evt_valley};
            e = exp_q.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL sync step %0d: got %h expected %h", i, obs, e);
            end
        end
        bus.sync = 1'b0;
    endtask
`endif

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1;
        test_reset();
        test_triangle();
        test_divider();
        test_sawtooth_mode_change();
        test_max_change();
        test_en_hold();
        test_zero_and_one_max();
`ifdef CARRIER_PHASE_SYNC_EN
        test_sync();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
